// File: rtl/msrv32_pkg.sv
// msrv32_pkg: constants and types shared by the integer register file and
// the rest of the core.
//   DATA_W / ADDR_W : architectural register width / register index width
//   X0_ADDR         : index of the hardwired-zero register
//   reg_addr_t      : register index type
//   xlen_t          : register data type
package msrv32_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] xlen_t;
endpackage

// File: rtl/msrv32_rf_read_port.sv
// msrv32_rf_read_port: one combinational read port of the integer file.
// Priority: x0 -> zero, then same-cycle write bypass, then stored entry.
// Optional build macro RF_PARITY_EN adds a parity check on the storage path.
// Ports:
//   i_addr        read address
//   i_byp_en      write enable already qualified with reset (bypass allowed)
//   i_rd_addr     write address
//   i_rd_data     write data
//   i_store_data  storage contents at i_addr
//   i_store_par   stored parity bit at i_addr      (RF_PARITY_EN only)
//   o_par_err     storage parity mismatch this cycle (RF_PARITY_EN only)
//   o_data        read data
import msrv32_pkg::*;

module msrv32_rf_read_port #(
  parameter int DATA_W = msrv32_pkg::DATA_W,
  parameter int ADDR_W = msrv32_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_byp_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic [DATA_W-1:0] i_store_data,
`ifdef RF_PARITY_EN
  input  logic              i_store_par,
  output logic              o_par_err,
`endif
  output logic [DATA_W-1:0] o_data
);

  logic w_is_x0;
  logic w_byp;

  assign w_is_x0 = (i_addr == ADDR_W'(X0_ADDR));
  assign w_byp   = i_byp_en && (i_rd_addr == i_addr);

  always_comb begin
    o_data = i_store_data;
    if (w_is_x0)    o_data = '0;
    else if (w_byp) o_data = i_rd_data;
  end

`ifdef RF_PARITY_EN
  // Only the storage path is checked; x0 and bypassed data never touch the
  // stored parity bit.
  assign o_par_err = !w_is_x0 && !w_byp && ((^i_store_data) != i_store_par);
`endif

endmodule

// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file: architectural integer register file x0..x31.
// Two asynchronous read ports with same-cycle write bypass, one synchronous
// write port, x0 hardwired to zero, synchronous active-high reset clearing
// every entry in one cycle.
// Optional build macro RF_PARITY_EN: per-entry even parity, error injection
// on write, sticky parity error output.
// Ports:
//   ms_riscv32_mp_clk_in  core clock
//   ms_riscv32_mp_rst_in  synchronous active-high reset
//   rs_1_addr_in/rs_2_addr_in  read addresses
//   rd_addr_in, wr_en_in, rd_in  write port
//   rs_1_out/rs_2_out     read data
//   err_inject_in         invert stored parity on write   (RF_PARITY_EN only)
//   parity_err_out        sticky parity error             (RF_PARITY_EN only)
import msrv32_pkg::*;

module msrv32_integer_file #(
  parameter int DATA_W   = msrv32_pkg::DATA_W,
  parameter int ADDR_W   = msrv32_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] rd_in,
`ifdef RF_PARITY_EN
  input  logic              err_inject_in,
  output logic              parity_err_out,
`endif
  output logic [DATA_W-1:0] rs_1_out,
  output logic [DATA_W-1:0] rs_2_out
);

  localparam int NUM_PORTS = 2;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_q;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_raddr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_rdata;

  // Reset wins: no write commit and no bypass in a reset cycle.
  assign w_wr_q  = wr_en_in && !ms_riscv32_mp_rst_in;
  assign w_raddr = {rs_2_addr_in, rs_1_addr_in};

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wr_en_in && (rd_addr_in != ADDR_W'(X0_ADDR))) begin
      r_regs[rd_addr_in] <= rd_in;
    end
  end

`ifdef RF_PARITY_EN
  logic [NUM_REGS-1:0]  r_par;
  logic [NUM_PORTS-1:0] w_port_err;
  logic                 r_par_err;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_par     <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (wr_en_in && (rd_addr_in != ADDR_W'(X0_ADDR)))
        r_par[rd_addr_in] <= (^rd_in) ^ err_inject_in;
      if (|w_port_err) r_par_err <= 1'b1;
    end
  end

  assign parity_err_out = r_par_err;
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    msrv32_rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .i_addr       (w_raddr[g]),
      .i_byp_en     (w_wr_q),
      .i_rd_addr    (rd_addr_in),
      .i_rd_data    (rd_in),
      .i_store_data (r_regs[w_raddr[g]]),
`ifdef RF_PARITY_EN
      .i_store_par  (r_par[w_raddr[g]]),
      .o_par_err    (w_port_err[g]),
`endif
      .o_data       (w_rdata[g])
    );
  end

  assign rs_1_out = w_rdata[0];
  assign rs_2_out = w_rdata[1];

endmodule
